half_adder_reg: RTL and testbench
=================================

Name: half_adder_reg

Overview:
- Registered, lane-parallel half adder: WIDTH independent 1-bit half adders (sum = a XOR b, cout = a AND b per lane).
- Results are captured on a valid strobe and presented one cycle later.
- Used as a leaf arithmetic primitive in datapaths needing a clocked half-add stage; WIDTH=1 is the canonical single-bit half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a and b for capture this cycle.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  registered per-lane sum bit.
- cout  output  WIDTH  registered per-lane carry-out bit.
- out_valid  output  1  high for exactly the cycle after an accepted input.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset values: sum=0, cout=0, out_valid=0. Reset has priority over in_valid in the same cycle.
- Per-lane function, for lane i: sum[i] = a[i] ^ b[i]; cout[i] = a[i] & b[i]. Lanes never interact; no carry propagates between lanes.
- Truth table per lane (a,b -> sum,cout): 00->00, 01->10, 10->10, 11->01.
- Latency: 1 cycle. in_valid=1 at edge N -> sum/cout updated and out_valid=1 after edge N.
- in_valid=0 at an edge: sum/cout hold their previous values; out_valid=0.
- Back-to-back in_valid: full throughput, one result per cycle; out_valid stays high continuously.
- Reset mid-stream: the next edge with rst=1 clears outputs regardless of in_valid. A transaction presented in that cycle is dropped, with no out_valid for it.
- X on a/b while in_valid=0 must not affect outputs.
- No handshake back-pressure; the block always accepts.

Optional Feature:
- Macro HALF_ADDER_REG_STATS_EN.
- Defined:
  - adds output carry_count (16 bits), a saturating counter of accepted transactions (in_valid=1) in which any cout bit of the result is 1.
  - increments on the same edge the result is registered.
  - holds at 16'hFFFF once reached.
  - cleared to 0 by rst.
- Not defined: port carry_count and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=1, b=1 -> sum=0, cout=0, out_valid=0 after each edge.
- WIDTH=1 truth table: apply (a,b)=00,01,10,11 with in_valid=1 on consecutive cycles -> after each edge (sum,cout)=00,10,10,01, and out_valid stays 1 for all four cycles.
- Hold: after a=1,b=1 is accepted, drive in_valid=0 with a=0,b=1 -> sum=0, cout=1 held; out_valid=0.
- WIDTH=4 lane independence: a=4'b1100, b=4'b1010, in_valid=1 -> sum=4'b0110, cout=4'b1000, out_valid=1 next cycle.
- Reset mid-stream: in_valid=1 with a=1,b=0 and rst=1 in the same cycle -> sum=0, out_valid=0. The next cycle with rst=0, in_valid=1, a=1, b=0 -> sum=1, cout=0, out_valid=1.
- Stats (HALF_ADDER_REG_STATS_EN): accept 3 transactions with a=1,b=1 and 2 with a=1,b=0 -> carry_count=3. After rst -> carry_count=0.

Source files
------------

// File: rtl/half_adder_reg.sv
// Registered lane-parallel half adder: WIDTH independent lanes, one-cycle latency.
// Optional HALF_ADDER_REG_STATS_EN adds a saturating count of accepted results with any carry set.
module half_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
`ifdef HALF_ADDER_REG_STATS_EN
  output logic [15:0]      carry_count,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Next-state: capture on in_valid, otherwise hold results and drop valid
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = a ^ b;
      cout_d      = a & b;
      out_valid_d = 1'b1;
    end else begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = 1'b0;
    end
  end

  // Result registers with synchronous reset taking priority over capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef HALF_ADDER_REG_STATS_EN
  logic [15:0] carry_count_d, carry_count_q;

  // Count accepted results with any carry, saturating at all-ones
  always_comb begin
    carry_count_d = carry_count_q;
    if (in_valid && (|(a & b)) && (carry_count_q != 16'hFFFF)) begin
      carry_count_d = carry_count_q + 16'd1;
    end else begin
      carry_count_d = carry_count_q;
    end
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count_q <= 16'd0;
    end else begin
      carry_count_q <= carry_count_d;
    end
  end

  assign carry_count = carry_count_q;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// Bench for half_adder_reg: WIDTH=1 and WIDTH=4 instances against an arithmetic reference model.
module tb_half_adder_reg;

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [0:0] a1, b1, sum1, cout1;
  logic [3:0] a4, b4, sum4, cout4;
  logic       ov1, ov4;
`ifdef HALF_ADDER_REG_STATS_EN
  logic [15:0] cc1, cc4;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [0:0] e1_sum, e1_cout;
  logic [3:0] e4_sum, e4_cout;
  logic       e_valid;
  int         e_cnt1, e_cnt4;

  always #5 clk = ~clk;

  half_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .sum(sum1), .cout(cout1),
`ifdef HALF_ADDER_REG_STATS_EN
    .carry_count(cc1),
`endif
    .out_valid(ov1)
  );

  half_adder_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .sum(sum4), .cout(cout4),
`ifdef HALF_ADDER_REG_STATS_EN
    .carry_count(cc4),
`endif
    .out_valid(ov4)
  );

  // Each lane is a two-bit arithmetic sum: low bit is sum, high bit is carry.
  function automatic logic [7:0] ref_add(input logic [3:0] x, input logic [3:0] y, input int w);
    logic [3:0] s, c;
    int t;
    s = 4'd0;
    c = 4'd0;
    for (int i = 0; i < w; i++) begin
      t = int'(x[i]) + int'(y[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    return {c, s};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [0:0] xa1, input logic [0:0] xb1,
                      input logic [3:0] xa4, input logic [3:0] xb4);
    logic [7:0] res1, res4;
    rst = r; in_valid = v; a1 = xa1; b1 = xb1; a4 = xa4; b4 = xb4;
    @(posedge clk);
    #1;
    if (r) begin
      e1_sum = 1'b0; e1_cout = 1'b0; e4_sum = 4'd0; e4_cout = 4'd0;
      e_valid = 1'b0; e_cnt1 = 0; e_cnt4 = 0;
    end else if (v) begin
      res1 = ref_add({3'd0, xa1}, {3'd0, xb1}, 1);
      res4 = ref_add(xa4, xb4, 4);
      e1_sum = res1[0]; e1_cout = res1[4];
      e4_sum = res4[3:0]; e4_cout = res4[7:4];
      e_valid = 1'b1;
      if (res1[7:4] != 4'd0 && e_cnt1 < 65535) e_cnt1++;
      if (res4[7:4] != 4'd0 && e_cnt4 < 65535) e_cnt4++;
    end else begin
      e_valid = 1'b0;
    end
    chk("sum_w1",  {15'd0, sum1},  {15'd0, e1_sum});
    chk("cout_w1", {15'd0, cout1}, {15'd0, e1_cout});
    chk("valid_w1", {15'd0, ov1},  {15'd0, e_valid});
    chk("sum_w4",  {12'd0, sum4},  {12'd0, e4_sum});
    chk("cout_w4", {12'd0, cout4}, {12'd0, e4_cout});
    chk("valid_w4", {15'd0, ov4},  {15'd0, e_valid});
`ifdef HALF_ADDER_REG_STATS_EN
    chk("cnt_w1", cc1, 16'(e_cnt1));
    chk("cnt_w4", cc4, 16'(e_cnt4));
`endif
  endtask

  initial begin
    logic       rr, vv;
    logic [0:0] ra1, rb1;
    logic [3:0] ra4, rb4;
    rst = 1'b1; in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = 4'd0; b4 = 4'd0;

    // Reset with a live transaction presented
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    // Truth table back-to-back
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0011);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b0110);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);
    // Hold with changed inputs, then X inputs while idle
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1010);
    step(1'b0, 1'b0, 1'bx, 1'bx, 4'bxxxx, 4'bxxxx);
    // Lane independence
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 4'b1010);
    // Reset mid-stream drops the transaction; next one goes through
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0100);
    // Statistics scenario: 3 carrying, 2 non-carrying, then reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001);
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000);
`ifdef HALF_ADDER_REG_STATS_EN
    chk("cnt_three", cc1, 16'd3);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Randomized traffic with occasional resets and X while idle
    for (int i = 0; i < 80; i++) begin
      rr  = ($urandom_range(15) == 0);
      vv  = $urandom_range(1);
      ra1 = 1'($urandom); rb1 = 1'($urandom);
      ra4 = 4'($urandom); rb4 = 4'($urandom);
      if (!vv && $urandom_range(3) == 0) begin
        ra1 = 1'bx; rb1 = 1'bx; ra4 = 4'bxxxx; rb4 = 4'bxxxx;
      end
      step(rr, vv, ra1, rb1, ra4, rb4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
